// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Architectural register file geometry (R0 is hardwired zero)
    localparam int NREG_DEF  = 32;
    localparam int REG_IDX_W = 5;

    // Opcodes the decoder maps onto id_is_halt / id_is_branch
    localparam logic [5:0] OP_HLT   = 6'h3F;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEQZ = 6'h05;

    // Control FSM encoding
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_BR_WAIT = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write counters with one increment and one
//            decrement port; reports busy/full vectors and an error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = 2
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 i_inc_en,
    input  logic [REG_IDX_W-1:0] i_inc_idx,
    input  logic                 i_dec_en,
    input  logic [REG_IDX_W-1:0] i_dec_idx,
    output logic [NREG-1:0]      o_busy,
    output logic [NREG-1:0]      o_full,
    output logic                 o_any_busy,
    output logic                 o_err
);

    logic [NREG-1:0] w_err;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            if (i == 0) begin : g_zero
                // R0 never holds a pending write
                assign o_busy[i] = 1'b0;
                assign o_full[i] = 1'b0;
                assign w_err[i]  = 1'b0;
            end else begin : g_cnt
                localparam logic [REG_IDX_W-1:0] c_IDX = REG_IDX_W'(i);
                logic [CNT_W-1:0] r_cnt;
                logic             w_inc;
                logic             w_dec;

                assign w_inc = i_inc_en && (i_inc_idx == c_IDX);
                assign w_dec = i_dec_en && (i_dec_idx == c_IDX);

                // Counter saturates at both ends; simultaneous inc+dec cancel
                always_ff @(posedge clk1 or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                    end else if (w_inc && !w_dec && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                assign w_err[i]  = (w_inc && !w_dec && (r_cnt == '1)) ||
                                   (w_dec && !w_inc && (r_cnt == '0));
                assign o_busy[i] = |r_cnt;
                assign o_full[i] = &r_cnt;
            end
        end
    endgenerate

    assign o_any_busy = |o_busy;
    assign o_err      = |w_err;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : ID-stage interlock: RAW/counter-full stalls, branch wait/flush,
//            and HLT drain sequencing on top of a pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = 2
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_src1_used,
    input  logic                 id_src2_used,
    input  logic [REG_IDX_W-1:0] id_dst,
    input  logic                 id_wr_en,
    input  logic                 id_is_branch,
    input  logic                 id_is_halt,
    input  logic                 ex_br_resolved,
    input  logic                 ex_br_taken,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dst,
    output logic                 issue,
    output logic                 stall,
    output logic                 flush_ifid,
    output logic                 halted,
    output logic                 sb_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_full;
    logic            w_any_busy;
    logic            w_sb_err_evt;
    logic            w_can_issue;
    logic            w_issue;
    logic            w_stall;
    logic            w_flush;
    logic            w_halted;
    logic            r_sb_err;

    // HLT issues but never reserves a destination
    hazard_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .i_inc_en   (w_issue & id_wr_en & ~id_is_halt),
        .i_inc_idx  (id_dst),
        .i_dec_en   (wb_valid),
        .i_dec_idx  (wb_dst),
        .o_busy     (w_busy),
        .o_full     (w_full),
        .o_any_busy (w_any_busy),
        .o_err      (w_sb_err_evt)
    );

    assign w_can_issue = id_valid
                       & ~(id_src1_used & w_busy[id_src1])
                       & ~(id_src2_used & w_busy[id_src2])
                       & ~(id_wr_en & w_full[id_dst]);

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_issue && id_is_halt) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_issue && id_is_branch) begin
                    w_state_nxt = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (ex_br_resolved) begin
                    w_state_nxt = ex_br_taken ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH:  w_state_nxt = ST_RUN;
            ST_DRAIN: begin
                if (!w_any_busy) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Output decode per state
    always_comb begin
        w_issue  = 1'b0;
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_issue = w_can_issue;
                w_stall = id_valid & ~w_can_issue;
            end
            ST_BR_WAIT: w_stall = 1'b1;
            ST_FLUSH: begin
                w_stall = 1'b1;
                w_flush = 1'b1;
            end
            ST_DRAIN:  w_stall  = 1'b1;
            ST_HALTED: w_halted = 1'b1;
            default: ;
        endcase
    end

    // Sticky scoreboard error flag
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_err <= 1'b0;
        end else if (w_sb_err_evt) begin
            r_sb_err <= 1'b1;
        end
    end

    // Reset forces the handshake outputs low regardless of ID inputs
    assign issue      = rst_n & w_issue;
    assign stall      = rst_n & w_stall;
    assign flush_ifid = rst_n & w_flush;
    assign halted     = rst_n & w_halted;
    assign sb_err     = r_sb_err;

endmodule
`default_nettype wire
